mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of cycles from request issue to response before abort (legal range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 n_rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 MemRead  input  1  SHALL request a load.
REQ-005 MemWr  input  1  SHALL request a store.
REQ-006 funct3  input  3  SHALL give the access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 ALU_Out  input  32  SHALL carry the byte address.
REQ-008 rd2  input  32  SHALL carry the store data.
REQ-009 mem_rdata  input  32  SHALL carry the memory read word.
REQ-010 mem_gnt  input  1  SHALL be the memory request accept.
REQ-011 mem_rvalid  input  1  SHALL be the memory response, for both reads and write acks.
REQ-012 mem_req  output  1  SHALL be the memory request.
REQ-013 mem_we  output  1  SHALL be the write enable.
REQ-014 mem_addr  output  32  SHALL be the word address, {addr[31:2],2'b00}.
REQ-015 mem_wdata  output  32  SHALL be the lane-replicated store data.
REQ-016 mem_be  output  4  SHALL be the byte enables.
REQ-017 stall  output  1  SHALL freeze the pipeline while an access is outstanding.
REQ-018 load_data  output  32  SHALL be the extracted, extended load result.
REQ-019 load_valid  output  1  SHALL qualify load_data as a one-cycle pulse.
REQ-020 access_fault  output  1  SHALL pulse for one cycle on a misaligned access or an illegal funct3.
REQ-021 timeout  output  1  SHALL pulse for one cycle on an aborted access.

Function
REQ-022 The FSM SHALL have exactly the states IDLE, REQ, WAIT and RESP.
REQ-023 In IDLE, MemRead has priority: if MemRead and MemWr are both high, a load SHALL be performed.
REQ-024 A fault check SHALL apply in IDLE: word with addr[1:0]!=0, half with addr[0]!=0, any funct3 of 011/110/111 on a load, or any funct3 outside {000,001,010} on a store SHALL produce access_fault=1 (registered, the next cycle), remain in IDLE, issue no mem_req, and keep stall=0.
REQ-025 A legal request in IDLE SHALL set stall=1 combinationally in the same cycle, latch address, we, wdata, be and funct3, and transition to REQ.
REQ-026 In REQ, mem_req=1 and all mem_* outputs SHALL stay stable until mem_gnt=1 is seen; then the FSM transitions to WAIT with mem_req=0.
REQ-027 In WAIT, on mem_rvalid=1 the FSM SHALL transition to RESP; mem_rvalid seen outside WAIT SHALL be ignored.
REQ-028 In RESP, stall=0 and inputs SHALL be ignored; for a load, load_valid=1 and load_data is valid; for a store, load_valid=0; RESP SHALL then go to IDLE.
REQ-029 Minimum latency with gnt in REQ and rvalid in the next cycle: IDLE -> REQ -> WAIT -> RESP, with stall high for 3 cycles.
REQ-030 Store formatting SHALL be:
  - SB: wdata={4{rd2[7:0]}}, be=4'b0001<<addr[1:0]
  - SH: wdata={2{rd2[15:0]}}, be=addr[1]?4'b1100:4'b0011
  - SW: wdata=rd2, be=4'b1111
REQ-031 For loads, be SHALL be 4'b1111.
REQ-032 Load extraction SHALL select the byte or half lane by the latched addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through; load_data SHALL be registered from mem_rdata in the rvalid cycle.
REQ-033 A cycle counter SHALL clear on entry to REQ and increment in REQ and WAIT.
REQ-034 When the counter reaches TIMEOUT_CYCLES-1 without completion, the FSM SHALL drop mem_req, go to RESP with timeout=1, load_valid=0 and load_data=0.
REQ-035 mem_rvalid arriving in the same cycle as the timeout threshold SHALL complete normally, with no timeout.
REQ-036 load_valid, access_fault and timeout SHALL never be high simultaneously.

Reset
REQ-037 n_rst=0 SHALL immediately force state IDLE, counter 0, and all outputs to 0, including mem_req, stall and every pulse output.
REQ-038 A reset mid-access SHALL abandon the access with no response pulse after reset release; the first cycle after release SHALL be IDLE sampling inputs.

Verification
REQ-039 LW at 0x100, gnt immediate, rdata=0xDEADBEEF next cycle -> stall high 3 cycles, then load_valid=1 and load_data=0xDEADBEEF.
REQ-040 SB rd2=0x000000A5 at 0x203 -> mem_we=1, mem_addr=0x200, be=4'b1000, wdata=0xA5A5A5A5, load_valid never 1.
REQ-041 LB at 0x102 with rdata=0x00800000 -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-042 LH at 0x101 -> access_fault=1 for one cycle, mem_req and stall stay 0.
REQ-043 Read with gnt but no rvalid (TIMEOUT_CYCLES=16) -> timeout=1 for one cycle, 16 cycles after entry to REQ, stall released, load_valid=0.
REQ-044 n_rst pulsed low during WAIT -> mem_req and stall go 0 asynchronously, and a following LW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if : request/grant/response bus between the load-store
//                      controller and the data memory
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl : load/store unit that formats, issues and times out a
//                   single outstanding data-memory access
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              MemRead,
    input  logic              MemWr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       ALU_Out,
    input  logic [31:0]       rd2,
    mem_access_ctrl_if.master mem,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              access_fault,
    output logic              timeout
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_req  = 2'd1;
    localparam logic [1:0] c_wait = 2'd2;
    localparam logic [1:0] c_resp = 2'd3;

    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_load_data;
    logic        r_load_ok;
    logic        r_fault;
    logic        r_timeout;

    logic        w_store;
    logic        w_any;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_fault;
    logic        w_start;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_ext;
    logic        w_at_limit;

    // MemRead wins when both are requested, so a store is only seen alone
    assign w_store    = MemWr & ~MemRead;
    assign w_any      = MemRead | MemWr;
    assign w_fault    = w_any & (w_illegal | w_misalign);
    assign w_start    = w_any & ~w_fault;
    assign w_at_limit = (r_cnt == c_cnt_last);

    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        case (funct3)
            3'b000, 3'b100: w_misalign = 1'b0;
            3'b001, 3'b101: w_misalign = ALU_Out[0];
            3'b010:         w_misalign = |ALU_Out[1:0];
            default:        w_illegal  = 1'b1;
        endcase
        if (w_store && funct3[2]) begin
            w_illegal = 1'b1;
        end
    end

    always_comb begin
        w_wdata = 32'h0;
        w_be    = 4'b1111;
        if (w_store) begin
            case (funct3[1:0])
                2'b00: begin
                    w_wdata = {4{rd2[7:0]}};
                    w_be    = 4'b0001 << ALU_Out[1:0];
                end
                2'b01: begin
                    w_wdata = {2{rd2[15:0]}};
                    w_be    = ALU_Out[1] ? 4'b1100 : 4'b0011;
                end
                default: w_wdata = rd2;
            endcase
        end
    end

    always_comb begin
        case (r_addr[1:0])
            2'd1:    w_lane_b = mem.mem_rdata[15:8];
            2'd2:    w_lane_b = mem.mem_rdata[23:16];
            2'd3:    w_lane_b = mem.mem_rdata[31:24];
            default: w_lane_b = mem.mem_rdata[7:0];
        endcase
        w_lane_h = r_addr[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_lane_b[7]}}, w_lane_b};
            3'b100:  w_ext = {24'h0, w_lane_b};
            3'b001:  w_ext = {{16{w_lane_h[15]}}, w_lane_h};
            3'b101:  w_ext = {16'h0, w_lane_h};
            default: w_ext = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= c_idle;
            r_cnt       <= 8'h0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_be        <= 4'h0;
            r_we        <= 1'b0;
            r_funct3    <= 3'h0;
            r_load_data <= 32'h0;
            r_load_ok   <= 1'b0;
            r_fault     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_load_ok <= 1'b0;
            r_fault   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_fault) begin
                        r_fault <= 1'b1;
                    end else if (w_start) begin
                        r_addr   <= ALU_Out;
                        r_wdata  <= w_wdata;
                        r_be     <= w_be;
                        r_we     <= w_store;
                        r_funct3 <= funct3;
                        r_cnt    <= 8'h0;
                        r_state  <= c_req;
                    end
                end
                c_req: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_at_limit) begin
                        r_timeout   <= 1'b1;
                        r_load_data <= 32'h0;
                        r_state     <= c_resp;
                    end else if (mem.mem_gnt) begin
                        r_state <= c_wait;
                    end
                end
                c_wait: begin
                    r_cnt <= r_cnt + 8'd1;
                    // a response on the last allowed cycle still counts as completion
                    if (mem.mem_rvalid) begin
                        if (!r_we) begin
                            r_load_data <= w_ext;
                            r_load_ok   <= 1'b1;
                        end
                        r_state <= c_resp;
                    end else if (w_at_limit) begin
                        r_timeout   <= 1'b1;
                        r_load_data <= 32'h0;
                        r_state     <= c_resp;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign mem.mem_req   = (r_state == c_req);
    assign mem.mem_we    = r_we & (r_state == c_req);
    assign mem.mem_addr  = {r_addr[31:2], 2'b00};
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_be    = r_be;

    // gated by n_rst so a request held during reset cannot raise stall
    assign stall = n_rst & (((r_state == c_idle) & w_start) |
                            (r_state == c_req) | (r_state == c_wait));

    assign load_data    = r_load_data;
    assign load_valid   = r_load_ok;
    assign access_fault = r_fault;
    assign timeout      = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl : directed vector bench for mem_access_ctrl
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_ctrl;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        fault;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        lv;
        logic [31:0] ldata;
    } vec_t;

    localparam int c_nvec = 16;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        mem_read;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] rd2;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_fault;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs [c_nvec];

    mem_access_ctrl_if mif ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .MemRead      (mem_read),
        .MemWr        (mem_wr),
        .funct3       (funct3),
        .ALU_Out      (alu_out),
        .rd2          (rd2),
        .mem          (mif),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .access_fault (access_fault),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        mem_read = v.rd; mem_wr = v.wr; funct3 = v.f3; alu_out = v.addr; rd2 = v.wd;
        #1 check_b({t, " stall_issue"}, stall, ~v.fault);
        @(negedge clk);
        mem_read = 1'b0; mem_wr = 1'b0;
        #1;
        if (v.fault) begin
            check_b({t, " fault_pulse"}, access_fault, 1'b1);
            check_b({t, " fault_no_req"}, mif.mem_req, 1'b0);
            check_b({t, " fault_no_stall"}, stall, 1'b0);
            @(negedge clk);
            #1 check_b({t, " fault_one_cycle"}, access_fault, 1'b0);
            check_b({t, " fault_no_req2"}, mif.mem_req, 1'b0);
        end else begin
            check_b({t, " req"}, mif.mem_req, 1'b1);
            check_b({t, " stall_req"}, stall, 1'b1);
            check_b({t, " we"}, mif.mem_we, v.we);
            check_w({t, " addr"}, mif.mem_addr, v.maddr);
            check_w({t, " be"}, {28'h0, mif.mem_be}, {28'h0, v.be});
            if (v.we) check_w({t, " wdata"}, mif.mem_wdata, v.wdata);
            check_b({t, " no_fault"}, access_fault, 1'b0);
            mif.mem_gnt = 1'b1;
            @(negedge clk);
            mif.mem_gnt = 1'b0;
            #1 check_b({t, " req_drop"}, mif.mem_req, 1'b0);
            check_b({t, " stall_wait"}, stall, 1'b1);
            mif.mem_rdata = v.rdata; mif.mem_rvalid = 1'b1;
            @(negedge clk);
            mif.mem_rvalid = 1'b0;
            #1 check_b({t, " stall_resp"}, stall, 1'b0);
            check_b({t, " lv"}, load_valid, v.lv);
            if (v.lv) check_w({t, " ldata"}, load_data, v.ldata);
            check_b({t, " no_timeout"}, timeout, 1'b0);
            @(negedge clk);
            #1 check_b({t, " lv_one_cycle"}, load_valid, 1'b0);
            check_b({t, " idle_stall"}, stall, 1'b0);
        end
    endtask

    initial begin
        //          rd    wr    f3      addr          rd2           rdata         flt   we    maddr         be       wdata         lv    ldata
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,        1'b0, 1'b1, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h0080_0000, 1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h0080_0000, 1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'h0000_0080};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h1234_BEEF, 32'h0,        1'b0, 1'b1, 32'h0000_0300, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b1, 32'h0000_0404, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0502, 32'h0,        32'h89AB_1234, 1'b0, 1'b0, 32'h0000_0500, 4'b1111, 32'h0,        1'b1, 32'h0000_89AB};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0500, 32'h0,        32'h89AB_9234, 1'b0, 1'b0, 32'h0000_0500, 4'b1111, 32'h0,        1'b1, 32'hFFFF_9234};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'hFFFF_FF3C, 32'h0,        1'b0, 1'b1, 32'h0000_0200, 4'b0010, 32'h3C3C_3C3C, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h0000_0600, 32'h5555_5555, 32'h1122_3344, 1'b0, 1'b0, 32'h0000_0600, 4'b1111, 32'h0,        1'b1, 32'h1122_3344};
        vecs[14] = '{1'b0, 1'b1, 3'b001, 32'h0000_0303, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h7F00_0000, 1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'h0000_007F};

        n_rst = 1'b0;
        mem_read = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; alu_out = 32'h0; rd2 = 32'h0;
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;

        // reset state, with a load request held to prove stall is forced low
        @(negedge clk);
        @(negedge clk);
        #1 check_b("rst stall", stall, 1'b0);
        check_b("rst req", mif.mem_req, 1'b0);
        check_b("rst we", mif.mem_we, 1'b0);
        check_w("rst addr", mif.mem_addr, 32'h0);
        check_w("rst be", {28'h0, mif.mem_be}, 32'h0);
        check_b("rst lv", load_valid, 1'b0);
        check_b("rst fault", access_fault, 1'b0);
        check_b("rst timeout", timeout, 1'b0);
        check_w("rst ldata", load_data, 32'h0);
        @(negedge clk);
        mem_read = 1'b0;
        n_rst = 1'b1;

        for (int i = 0; i < c_nvec; i++) begin
            run_vec(i, vecs[i]);
        end

        // timeout: granted read that never gets a response
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h0000_0700;
        @(negedge clk);
        mem_read = 1'b0; mif.mem_gnt = 1'b1;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            mif.mem_gnt = 1'b0;
            #1 check_b($sformatf("to c%0d stall", k), stall, 1'b1);
            check_b($sformatf("to c%0d timeout", k), timeout, 1'b0);
        end
        @(negedge clk);
        #1 check_b("to pulse", timeout, 1'b1);
        check_b("to stall_rel", stall, 1'b0);
        check_b("to lv", load_valid, 1'b0);
        check_w("to ldata", load_data, 32'h0);
        check_b("to req", mif.mem_req, 1'b0);
        mif.mem_rvalid = 1'b1;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        #1 check_b("to one_cycle", timeout, 1'b0);
        check_b("to late_rvalid_stall", stall, 1'b0);
        @(negedge clk);
        #1 check_b("to late_rvalid_lv", load_valid, 1'b0);

        // delayed grant, stray rvalid in REQ, response on the threshold cycle
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h0000_0710;
        @(negedge clk);
        mem_read = 1'b0;
        #1 check_b("th c0 req", mif.mem_req, 1'b1);
        @(negedge clk);
        #1 check_w("th c1 addr", mif.mem_addr, 32'h0000_0710);
        check_b("th c1 req", mif.mem_req, 1'b1);
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        #1 check_b("th c2 req_held", mif.mem_req, 1'b1);
        check_b("th c2 stall", stall, 1'b1);
        check_b("th c2 no_lv", load_valid, 1'b0);
        mif.mem_gnt = 1'b1;
        @(negedge clk);
        mif.mem_gnt = 1'b0;
        #1 check_b("th c3 req_drop", mif.mem_req, 1'b0);
        for (int k = 4; k <= 15; k++) begin
            @(negedge clk);
        end
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h5A5A_0001;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        #1 check_b("th lv", load_valid, 1'b1);
        check_w("th ldata", load_data, 32'h5A5A_0001);
        check_b("th no_timeout", timeout, 1'b0);
        check_b("th stall", stall, 1'b0);

        // reset pulsed while waiting for a response
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h0000_0800;
        @(negedge clk);
        mem_read = 1'b0; mif.mem_gnt = 1'b1;
        @(negedge clk);
        mif.mem_gnt = 1'b0;
        @(negedge clk);
        #1 check_b("rw stall_before", stall, 1'b1);
        mem_read = 1'b1; alu_out = 32'h0000_0900;
        #1 n_rst = 1'b0;
        #1 check_b("rw async_stall", stall, 1'b0);
        check_b("rw async_req", mif.mem_req, 1'b0);
        check_b("rw lv", load_valid, 1'b0);
        check_b("rw timeout", timeout, 1'b0);
        @(negedge clk);
        mem_read = 1'b0;
        n_rst = 1'b1;
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h2222_2222;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mif.mem_rvalid = 1'b0;
            #1 check_b($sformatf("rw post%0d lv", k), load_valid, 1'b0);
            check_b($sformatf("rw post%0d timeout", k), timeout, 1'b0);
            check_b($sformatf("rw post%0d stall", k), stall, 1'b0);
            check_b($sformatf("rw post%0d req", k), mif.mem_req, 1'b0);
        end
        run_vec(100, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
